// File: rtl/blackjack_button_frontend.sv
// Button/switch conditioning for the blackjack controller: 2-flop sync, debounce,
// armed edge detect and priority arbitration. Define DEBOUNCE_BYPASS_EN to skip debounce.
module blackjack_button_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next_raw,
  input  logic       btn_hit_raw,
  input  logic       btn_stand_raw,
  input  logic       btn_double_raw,
  input  logic       btn_split_raw,
  input  logic [3:0] sw_bet_raw,
  output logic       next,
  output logic       hit,
  output logic       stand,
  output logic       double,
  output logic       split,
  output logic       bet_8,
  output logic       bet_4,
  output logic       bet_2,
  output logic       bet_1,
  output logic [3:0] bet_value,
  output logic       any_held
);

  localparam int unsigned N = 9;

  // bit 0 next, 1 hit, 2 stand, 3 double, 4 split, 8:5 bet switches
  logic [N-1:0] raw;
  logic [N-1:0] s1;
  logic [N-1:0] s2;
  logic [N-1:0] deb;
  logic [4:0]   deb_d;
  logic [4:0]   armed;
  logic [4:0]   cand;
  logic [4:0]   win;
  logic [4:0]   cmd;
  logic [1:0]   sync_vld;

  assign raw = {sw_bet_raw, btn_split_raw, btn_double_raw, btn_stand_raw,
                btn_hit_raw, btn_next_raw};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

`ifdef DEBOUNCE_BYPASS_EN
  assign deb = s2;
`else
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt [N];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb <= '0;
      for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end
`endif

  // s2 holds its reset value for two edges; arming only trusts it once the
  // synchronizer has carried a real sample, so a button held through reset stays unarmed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_vld <= '0;
      armed    <= '0;
      deb_d    <= '0;
    end else begin
      sync_vld <= {sync_vld[0], 1'b1};
      armed    <= armed | ({5{sync_vld[1]}} & ~s2[4:0]);
      deb_d    <= deb[4:0];
    end
  end

  assign cand = deb[4:0] & ~deb_d & armed;

  // priority next > stand > hit > double > split; losers are dropped
  always_comb begin
    win = '0;
    if (cand[0])      win[0] = 1'b1;
    else if (cand[2]) win[2] = 1'b1;
    else if (cand[1]) win[1] = 1'b1;
    else if (cand[3]) win[3] = 1'b1;
    else if (cand[4]) win[4] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cmd <= '0;
    else        cmd <= win;
  end

  assign next      = cmd[0];
  assign hit       = cmd[1];
  assign stand     = cmd[2];
  assign double    = cmd[3];
  assign split     = cmd[4];
  assign bet_1     = deb[5];
  assign bet_2     = deb[6];
  assign bet_4     = deb[7];
  assign bet_8     = deb[8];
  assign bet_value = deb[8:5];
  assign any_held  = |deb[4:0];

endmodule

// File: doc/blackjack_button_frontend.md
# blackjack_button_frontend

Input conditioning stage between the board's raw push-buttons/slide switches and the `top` game controller. Synchronizes, debounces and edge-detects the five action buttons into one-cycle, mutually exclusive command pulses (`next`, `hit`, `stand`, `double`, `split`). Synchronizes and debounces the four bet switches into stable levels. It drives the same button/bet pins that the game FSM consumes, so the FSM never sees bounce, metastability or multi-cycle presses.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a debounced state changes; legal range ≥1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_next_raw`, `btn_hit_raw`, `btn_stand_raw`, `btn_double_raw`, `btn_split_raw`  in  1 each  raw asynchronous buttons, active-high.
- `sw_bet_raw`  in  4  raw bet switches; bit3=8, bit2=4, bit1=2, bit0=1.
- `next`, `hit`, `stand`, `double`, `split`  out  1 each  one-cycle command pulses, at most one high per cycle.
- `bet_8`, `bet_4`, `bet_2`, `bet_1`  out  1 each  debounced bet switch levels.
- `bet_value`  out  4  `{bet_8,bet_4,bet_2,bet_1}`.
- `any_held`  out  1  OR of the five debounced action-button levels.

## Operation
- Per input (5 buttons + 4 switches), three stages run:
  - Synchronizer: two flops, `s1`→`s2`.
  - Debouncer: registered state `deb` plus counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
    - While `s2 != deb`, `cnt` increments each cycle.
    - When `s2 == deb`, `cnt` clears to 0, so any glitch restarts the count.
    - When `cnt` reaches `DEBOUNCE_CYCLES-1` and `s2 != deb` still holds, `deb <= s2` and `cnt <= 0` on that edge.
  - Arm bit (buttons only): cleared by reset; set on the first edge where `s2 == 0`; never cleared except by reset.
- A button's rising candidate is `deb & ~deb_d & armed`, where `deb_d` is `deb` delayed one cycle. A button held through reset release therefore produces no pulse until it has been released and pressed again.
- Arbitration when several candidates occur in the same cycle: priority `next` > `stand` > `hit` > `double` > `split`. Only the winner pulses; losers are discarded, not queued.
- Command outputs are registered: a pulse is high for exactly one cycle, on the edge after the candidate cycle.
- Releasing a button produces no output event. Holding a button produces exactly one pulse.
- Bet switches produce no pulses. `bet_*` equal their `deb` values directly; there is no arm bit.
- Reset value of every output is 0. All internal flops, counters and arm bits also reset to 0.

## Timing
- Label edges from E0, the first edge at which a raw input change is sampled into `s1`. Let D = `DEBOUNCE_CYCLES`.
- `s2` changes at E1. `deb` changes at E(1+D), given the input stays stable throughout.
- Command pulse: high during the cycle after E(2+D), i.e. latency is 2+D edges.
- Bet level change: latency 1+D edges.
- A bounce shorter than D cycles produces no change. A pulse of exactly D stable cycles is accepted.
- Asserting `reset` mid-count aborts the count immediately and forces all outputs to 0 asynchronously.
- Reset deassertion is synchronized by the system reset generator, not by this block.

## Configuration
- `DEBOUNCE_BYPASS_EN`, defined:
  - Debounce counters are not compiled, and `deb = s2` (equivalent to D=0).
  - Command latency is 2 edges; bet latency is 1 edge.
  - `DEBOUNCE_CYCLES` is ignored.
  - Used for simulation benches that hold buttons for only 2 clock cycles.
- `DEBOUNCE_BYPASS_EN`, undefined: full debounce as specified above.

## Test plan
- With D=4 and `btn_hit_raw` held high for 10 cycles from an armed state: `hit` is high for exactly one cycle, 6 edges after the press is first sampled. No other command pulses. `any_held` is 1 from edge 5 until release + 5.
- With D=4, `btn_stand_raw` toggles 1/0 every 2 cycles for 20 cycles, then is held high: no `stand` pulse during toggling. Exactly one pulse, 6 edges after the final stable high begins.
- With D=4, `btn_next_raw` and `btn_double_raw` rise on the same edge and are both held: only `next` pulses. `double` never pulses, and releasing `next` while still holding `double` produces nothing.
- `btn_split_raw` is held high across reset deassertion: no `split` pulse. After release for ≥D cycles and a re-press, one `split` pulse occurs.
- With D=4, `sw_bet_raw` goes 4'b0000→4'b0011: `bet_value` reads 3 after 5 edges, and `bet_2`=`bet_1`=1. `reset` asserted 2 cycles into a later change returns `bet_value` to 0 immediately.
- Compiled with `DEBOUNCE_BYPASS_EN`, a 2-cycle `btn_double_raw` press: `double` pulses one cycle, 2 edges after sampling.
